// File: rtl/phased_cache_ctrl.sv
// Lookup/fill controller for a 2-way, 4-set phased cache.
// Phase 1 reads tag and valid bits of both ways. Phase 2 reads data from the hit way only.
// On a miss the controller fetches the line from memory and fills a victim way.
//
// state | meaning
// IDLE  | ready for a new request
// TAG   | compare tags and valid bits of both ways
// DATA  | read data from the hit way
// MISS  | memory request outstanding
// FILL  | write the victim way
// RESP  | one-cycle response pulse
module phased_cache_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_hit,
   output logic [1:0]        index,
   output logic [3:0]        index_dec,
   output logic              tag_rd_en,
   output logic [1:0]        data_rd_en,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic [ADDR_W-3:0] tag_in0,
   input  logic [ADDR_W-3:0] tag_in1,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   output logic [1:0]        load,
   output logic [ADDR_W-3:0] fill_tag,
   output logic [DATA_W-1:0] fill_data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data
);

   typedef enum logic [2:0] {IDLE, TAG, DATA, MISS, FILL, RESP} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        lru;
   logic              hit_way;
   logic              victim;
   logic              hit0, hit1;
   logic              victim_sel;

   assign index     = addr_q[1:0];
   assign index_dec = 4'b0001 << index;
   assign fill_tag  = addr_q[ADDR_W-1:2];
   assign mem_addr  = addr_q;

   assign hit0 = valid_in0 && (tag_in0 == addr_q[ADDR_W-1:2]);
   assign hit1 = valid_in1 && (tag_in1 == addr_q[ADDR_W-1:2]);

   // Fill an invalid way first; only fall back to LRU when the set is full.
   assign victim_sel = !valid_in0 ? 1'b0 :
                       !valid_in1 ? 1'b1 : lru[index];

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and decoded array/memory strobes.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      tag_rd_en  = 1'b0;
      data_rd_en = 2'b00;
      mem_req    = 1'b0;
      load       = 2'b00;
      case (state)
         IDLE: begin
            // Gated by reset so every output except index_dec is low while in reset.
            req_ready = reset;
            if (req_valid) state_nxt = TAG;
         end
         TAG: begin
            tag_rd_en = 1'b1;
            state_nxt = (hit0 || hit1) ? DATA : MISS;
         end
         DATA: begin
            data_rd_en = hit_way ? 2'b10 : 2'b01;
            state_nxt  = RESP;
         end
         MISS: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = FILL;
         end
         FILL: begin
            load      = victim ? 2'b10 : 2'b01;
            state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, way selection, LRU and data capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q    <= '0;
         lru       <= 4'b0000;
         hit_way   <= 1'b0;
         victim    <= 1'b0;
         resp_data <= '0;
         resp_hit  <= 1'b0;
         fill_data <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) addr_q <= req_addr;
            TAG: begin
               // Way 0 wins if both ways claim a hit.
               hit_way <= !hit0;
               victim  <= victim_sel;
            end
            DATA: begin
               resp_data  <= hit_way ? data_in1 : data_in0;
               resp_hit   <= 1'b1;
               lru[index] <= ~hit_way;
            end
            MISS: if (mem_ack) begin
               fill_data <= mem_data;
               resp_data <= mem_data;
            end
            FILL: begin
               resp_hit   <= 1'b0;
               lru[index] <= ~victim;
            end
            default: ;
         endcase
      end
   end

endmodule
